core_sequencer: RTL and testbench

Fetch/decode/issue controller that sits directly upstream of the execute units (`alu`, `branch`, `data_mov`). It fetches one 32-bit instruction at a time from instruction memory, latches it, and drives register-file read addresses, the shared `opcode`/`has_imm`/`imm` fields and exactly one unit enable. It then waits for completion, commits ALU results and the PC, and advances. Execution is non-pipelined: one instruction is in flight.

---
 rtl/core_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_core_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_sequencer.sv
// core_sequencer: non-pipelined fetch/decode/issue controller for the
// alu / branch / data_mov execute units. One instruction in flight.
// Optional feature macro: SEQ_RETIRE_CNT_EN adds the retired_cnt output,
// a 32-bit wrapping count of WB cycles.
module core_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int unsigned DM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  output logic [4:0]  rf_raddrd,
  output logic [2:0]  opcode,
  output logic        has_imm,
  output logic [20:0] imm,
  output logic        alu_en,
  output logic        br_en,
  output logic        dm_en,
  input  logic [31:0] alu_y,
  input  logic [31:0] br_offset,
  input  logic        br_st_flag,
  input  logic        dm_done,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        halted,
  output logic        error
`ifdef SEQ_RETIRE_CNT_EN
  ,
  output logic [31:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERR
  } state_e;

  typedef enum logic [1:0] {
    U_ALU, U_BR, U_DM, U_SYS
  } unit_e;

  localparam int unsigned CW = $clog2(DM_TIMEOUT + 1);

  state_e        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   npc_q, npc_d;
  logic [31:0]   ir_q, ir_d;
  logic [31:0]   res_q, res_d;
  logic [CW-1:0] tmo_q, tmo_d;
  logic [CW-1:0] tmo_inc;
  unit_e         unit;

  assign unit    = unit_e'(ir_q[31:30]);
  assign tmo_inc = tmo_q + CW'(1);

  // Instruction fields come straight from IR, so they hold from DECODE to WB
  assign has_imm   = ir_q[29];
  assign opcode    = ir_q[28:26];
  assign rf_raddrd = ir_q[25:21];
  assign rf_raddr1 = ir_q[20:16];
  assign rf_raddr2 = ir_q[15:11];
  assign imm       = ir_q[20:0];
  assign imem_addr = pc_q;
  assign rf_waddr  = ir_q[25:21];
  assign rf_wdata  = res_q;

  // FSM state register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: begin
        if (unit == U_SYS) state_d = (ir_q[28:26] == 3'b000) ? S_HALT : S_ERR;
        else               state_d = S_EXEC;
      end
      S_EXEC: begin
        if (unit == U_DM) begin
          if (dm_done)                       state_d = S_WB;
          else if (tmo_inc == CW'(DM_TIMEOUT)) state_d = S_ERR;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB:     state_d = S_FETCH;
      default:  state_d = state_q;
    endcase
  end

  // FSM outputs; imem_req is masked while reset is held so the first request
  // appears only in the cycle after reset deasserts
  always_comb begin
    imem_req = 1'b0;
    alu_en   = 1'b0;
    br_en    = 1'b0;
    dm_en    = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    error    = 1'b0;
    case (state_q)
      S_FETCH: imem_req = ~reset;
      S_EXEC: begin
        alu_en = (unit == U_ALU);
        br_en  = (unit == U_BR);
        dm_en  = (unit == U_DM);
      end
      S_WB:    rf_we  = (unit == U_ALU);
      S_HALT:  halted = 1'b1;
      S_ERR:   error  = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: IR latch, next-PC staging, ALU capture, timeout count.
  // next-PC defaults to PC+1 in DECODE and is overridden by a taken branch,
  // so WB commits a single register regardless of unit.
  always_comb begin
    pc_d  = pc_q;
    npc_d = npc_q;
    ir_d  = ir_q;
    res_d = res_q;
    tmo_d = tmo_q;
    case (state_q)
      S_FETCH: if (imem_ack) ir_d = imem_rdata;
      S_DECODE: begin
        npc_d = pc_q + 32'd1;
        tmo_d = '0;
      end
      S_EXEC: begin
        if (unit == U_ALU) res_d = alu_y;
        if (unit == U_BR && br_st_flag) npc_d = br_offset;
        if (unit == U_DM && !dm_done) tmo_d = tmo_inc;
      end
      S_WB:    pc_d = npc_q;
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= RESET_PC;
      npc_q <= '0;
      ir_q  <= '0;
      res_q <= '0;
      tmo_q <= '0;
    end else begin
      pc_q  <= pc_d;
      npc_q <= npc_d;
      ir_q  <= ir_d;
      res_q <= res_d;
      tmo_q <= tmo_d;
    end
  end

`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] ret_q, ret_d;

  // Retired-instruction count: one per WB cycle, wrapping
  always_comb begin
    ret_d = ret_q;
    if (state_q == S_WB) ret_d = ret_q + 32'd1;
  end

  // Retired-instruction counter register
  always_ff @(posedge clk) begin
    if (reset) ret_q <= '0;
    else       ret_q <= ret_d;
  end

  assign retired_cnt = ret_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer.
// Covers SEQ_RETIRE_CNT_EN when the macro is defined for the build.
module tb_core_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_raddrd;
  logic [2:0]  opcode;
  logic        has_imm;
  logic [20:0] imm;
  logic        alu_en, br_en, dm_en;
  logic [31:0] alu_y;
  logic [31:0] br_offset;
  logic        br_st_flag;
  logic        dm_done;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        halted, error;
`ifdef SEQ_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  core_sequencer #(
    .RESET_PC  (32'h0),
    .DM_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_raddrd  (rf_raddrd),
    .opcode     (opcode),
    .has_imm    (has_imm),
    .imm        (imm),
    .alu_en     (alu_en),
    .br_en      (br_en),
    .dm_en      (dm_en),
    .alu_y      (alu_y),
    .br_offset  (br_offset),
    .br_st_flag (br_st_flag),
    .dm_done    (dm_done),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .halted     (halted),
    .error      (error)
`ifdef SEQ_RETIRE_CNT_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; imem_ack = 1'b1; imem_rdata = '0; alu_y = '0;
    br_offset = '0; br_st_flag = 1'b0; dm_done = 1'b0;
    step(); step();
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_checks++; if ({alu_en, br_en, dm_en} !== 3'b000) begin n_fail++; $display("FAIL reset_en: got %b expected 000", {alu_en, br_en, dm_en}); end
    n_checks++; if ({rf_we, halted, error} !== 3'b000) begin n_fail++; $display("FAIL reset_status: got %b expected 000", {rf_we, halted, error}); end
    n_checks++; if ({opcode, has_imm, imm} !== 25'h0) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", {opcode, has_imm, imm}); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", imem_addr); end
    reset = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL first_req: got %b expected 1", imem_req); end
  endtask

  task automatic test_alu_basic();
    imem_rdata = 32'h0000_0000;
    step(); // DECODE
    n_checks++; if (alu_en !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL alu_decode: got en=%b req=%b expected 0 0", alu_en, imem_req); end
    alu_y = 32'hDEAD_BEEF;
    step(); // EXEC
    n_checks++; if ({alu_en, br_en, dm_en, rf_we} !== 4'b1000) begin n_fail++; $display("FAIL alu_exec: got %b expected 1000", {alu_en, br_en, dm_en, rf_we}); end
    step(); // WB
    alu_y = 32'h1111_1111;
    n_checks++; if (rf_we !== 1'b1 || alu_en !== 1'b0) begin n_fail++; $display("FAIL alu_wb_we: got we=%b en=%b expected 1 0", rf_we, alu_en); end
    n_checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL alu_wb_data: got %0d/%h expected 0/deadbeef", rf_waddr, rf_wdata); end
    step(); // FETCH
    n_checks++; if (imem_addr !== 32'h1 || imem_req !== 1'b1 || rf_we !== 1'b0) begin n_fail++; $display("FAIL alu_next_pc: got %h req=%b we=%b expected 1 1 0", imem_addr, imem_req, rf_we); end
  endtask

  task automatic test_alu_fields();
    imem_rdata = {2'b00, 1'b1, 3'b101, 5'd7, 5'd3, 5'd9, 11'h155};
    step(); // DECODE
    n_checks++; if (opcode !== 3'd5 || has_imm !== 1'b1) begin n_fail++; $display("FAIL fld_op: got %0d/%b expected 5/1", opcode, has_imm); end
    n_checks++; if ({rf_raddrd, rf_raddr1, rf_raddr2} !== {5'd7, 5'd3, 5'd9}) begin n_fail++; $display("FAIL fld_regs: got %0d %0d %0d expected 7 3 9", rf_raddrd, rf_raddr1, rf_raddr2); end
    n_checks++; if (imm !== {5'd3, 5'd9, 11'h155}) begin n_fail++; $display("FAIL fld_imm: got %h expected %h", imm, {5'd3, 5'd9, 11'h155}); end
    alu_y = 32'h0000_00A5;
    step(); // EXEC
    step(); // WB
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hA5) begin n_fail++; $display("FAIL fld_wb: got %b/%0d/%h expected 1/7/a5", rf_we, rf_waddr, rf_wdata); end
    n_checks++; if (opcode !== 3'd5) begin n_fail++; $display("FAIL fld_stable: got %0d expected 5", opcode); end
    step(); // FETCH
    n_checks++; if (imem_addr !== 32'h2) begin n_fail++; $display("FAIL fld_next_pc: got %h expected 2", imem_addr); end
  endtask

  task automatic test_branch();
    imem_rdata = 32'h4000_0000;
    step(); // DECODE
    n_checks++; if (br_en !== 1'b0) begin n_fail++; $display("FAIL br_decode: got %b expected 0", br_en); end
    br_st_flag = 1'b1; br_offset = 32'h40;
    step(); // EXEC
    n_checks++; if ({alu_en, br_en, dm_en} !== 3'b010) begin n_fail++; $display("FAIL br_exec: got %b expected 010", {alu_en, br_en, dm_en}); end
    step(); // WB
    br_st_flag = 1'b0;
    n_checks++; if (br_en !== 1'b0 || rf_we !== 1'b0) begin n_fail++; $display("FAIL br_taken_wb: got en=%b we=%b expected 0 0", br_en, rf_we); end
    step(); // FETCH
    n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL br_taken_pc: got %h expected 40", imem_addr); end
    imem_rdata = 32'h4000_0000;
    step(); // DECODE
    br_offset = 32'h99;
    step(); // EXEC
    step(); // WB
    n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL br_nt_we: got %b expected 0", rf_we); end
    step(); // FETCH
    n_checks++; if (imem_addr !== 32'h41) begin n_fail++; $display("FAIL br_nt_pc: got %h expected 41", imem_addr); end
  endtask

  task automatic test_dm_wait();
    int en_cycles = 0;
    int guard = 0;
    logic we_seen = 1'b0;
    imem_rdata = 32'h8000_0000;
    step(); // DECODE
    n_checks++; if (dm_en !== 1'b0) begin n_fail++; $display("FAIL dm_decode: got %b expected 0", dm_en); end
    step(); // EXEC 1
    while (imem_req !== 1'b1 && guard < 20) begin
      if (rf_we === 1'b1) we_seen = 1'b1;
      if (dm_en === 1'b1) begin
        en_cycles++;
        if (en_cycles == 3) dm_done = 1'b1;
      end else begin
        dm_done = 1'b0;
      end
      step();
      guard++;
    end
    dm_done = 1'b0;
    n_checks++; if (en_cycles != 3) begin n_fail++; $display("FAIL dm_en_cycles: got %0d expected 3", en_cycles); end
    n_checks++; if (imem_addr !== 32'h42 || guard >= 20) begin n_fail++; $display("FAIL dm_next_pc: got %h (guard %0d) expected 42", imem_addr, guard); end
    n_checks++; if (we_seen !== 1'b0) begin n_fail++; $display("FAIL dm_no_we: got %b expected 0", we_seen); end
  endtask

  task automatic test_fetch_stall();
    int req_cycles = 0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0040_0000; // ALU op, rd = 2
    for (int i = 0; i < 6; i++) begin
      if (imem_req === 1'b1) req_cycles++;
      n_checks++; if (imem_addr !== 32'h42) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h expected 42", i, imem_addr); end
      if (i == 5) imem_ack = 1'b1;
      step();
    end
    n_checks++; if (req_cycles != 6 || imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req: got %0d cycles, req now %b expected 6, 0", req_cycles, imem_req); end
    alu_y = 32'h0;
    step(); // EXEC
    step(); // WB
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2) begin n_fail++; $display("FAIL stall_wb: got %b/%0d expected 1/2", rf_we, rf_waddr); end
    step(); // FETCH
    n_checks++; if (imem_addr !== 32'h43) begin n_fail++; $display("FAIL stall_next_pc: got %h expected 43", imem_addr); end
  endtask

  task automatic test_pc_wrap();
    imem_rdata = 32'h4000_0000;
    step(); // DECODE
    br_st_flag = 1'b1; br_offset = 32'hFFFF_FFFF;
    step(); // EXEC
    step(); // WB
    br_st_flag = 1'b0;
    step(); // FETCH
    n_checks++; if (imem_addr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_target: got %h expected ffffffff", imem_addr); end
    imem_rdata = 32'h0;
    step(); step(); step(); step();
    n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL wrap_pc: got %h req=%b expected 0 1", imem_addr, imem_req); end
  endtask

  task automatic test_dm_timeout();
    int exec_cycles = 0;
    int guard = 0;
    imem_rdata = 32'h8000_0000;
    dm_done = 1'b0;
    step(); // DECODE
    step(); // EXEC 1
    while (dm_en === 1'b1 && guard < 40) begin
      exec_cycles++;
      step();
      guard++;
    end
    n_checks++; if (exec_cycles != 16) begin n_fail++; $display("FAIL tmo_cycles: got %0d expected 16", exec_cycles); end
    n_checks++; if (error !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL tmo_err: got err=%b req=%b expected 1 0", error, imem_req); end
    step(); step(); step();
    n_checks++; if (error !== 1'b1 || imem_req !== 1'b0 || dm_en !== 1'b0) begin n_fail++; $display("FAIL tmo_sticky: got err=%b req=%b en=%b expected 1 0 0", error, imem_req, dm_en); end
  endtask

  task automatic test_system_halt();
    do_reset();
    n_checks++; if (error !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_from_err: got err=%b req=%b addr=%h expected 0 1 0", error, imem_req, imem_addr); end
    imem_rdata = 32'hC000_0000;
    step(); // DECODE
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_decode: got %b expected 0", halted); end
    step();
    n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0 || error !== 1'b0) begin n_fail++; $display("FAIL halt_enter: got h=%b req=%b err=%b expected 1 0 0", halted, imem_req, error); end
    step(); step(); step();
    n_checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin n_fail++; $display("FAIL halt_sticky: got h=%b req=%b expected 1 0", halted, imem_req); end
  endtask

  task automatic test_system_err();
    do_reset();
    n_checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_from_halt: got h=%b req=%b addr=%h expected 0 1 0", halted, imem_req, imem_addr); end
    imem_rdata = 32'hC400_0000;
    step(); // DECODE
    step();
    n_checks++; if (error !== 1'b1 || halted !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL sys_err: got err=%b h=%b req=%b expected 1 0 0", error, halted, imem_req); end
    do_reset();
    n_checks++; if (error !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_from_err2: got err=%b addr=%h req=%b expected 0 0 1", error, imem_addr, imem_req); end
  endtask

`ifdef SEQ_RETIRE_CNT_EN
  task automatic test_retire_count();
    do_reset();
    n_checks++; if (retired_cnt !== 32'd0) begin n_fail++; $display("FAIL ret_reset: got %0d expected 0", retired_cnt); end
    imem_rdata = 32'h0;
    for (int i = 0; i < 10; i++) begin
      step(); step(); step(); step();
    end
    n_checks++; if (retired_cnt !== 32'd10 || imem_addr !== 32'd10) begin n_fail++; $display("FAIL ret_count: got %0d pc=%h expected 10 pc=a", retired_cnt, imem_addr); end
  endtask
`endif

  task automatic test_reset_mid_exec();
    do_reset();
    imem_rdata = 32'h0;
    step(); step(); step(); step(); // one full ALU op, PC -> 1
    n_checks++; if (imem_addr !== 32'h1) begin n_fail++; $display("FAIL mid_pre_pc: got %h expected 1", imem_addr); end
    imem_rdata = 32'h0060_0000; // ALU op, rd = 3
    alu_y = 32'h5555_AAAA;
    step(); // DECODE
    step(); // EXEC
    n_checks++; if (alu_en !== 1'b1) begin n_fail++; $display("FAIL mid_exec_en: got %b expected 1", alu_en); end
    reset = 1'b1;
    step();
    n_checks++; if (rf_we !== 1'b0 || alu_en !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL mid_abort: got we=%b en=%b req=%b expected 0 0 0", rf_we, alu_en, imem_req); end
`ifdef SEQ_RETIRE_CNT_EN
    n_checks++; if (retired_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_ret: got %0d expected 0", retired_cnt); end
`endif
    reset = 1'b0;
    #1;
    n_checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || rf_we !== 1'b0) begin n_fail++; $display("FAIL mid_restart: got addr=%h req=%b we=%b expected 0 1 0", imem_addr, imem_req, rf_we); end
  endtask

  initial begin
    test_reset();
    test_alu_basic();
    test_alu_fields();
    test_branch();
    test_dm_wait();
    test_fetch_stall();
    test_pc_wrap();
    test_dm_timeout();
    test_system_halt();
    test_system_err();
`ifdef SEQ_RETIRE_CNT_EN
    test_retire_count();
`endif
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "watchdog expired");
  end

endmodule
